ahbl_txn_monitor: RTL and testbench
===================================

// Module: ahbl_txn_monitor
// PURPOSE
//  Passive AHB-lite bus monitor that taps a slave port and tracks the address-phase/data-phase pipeline.
//  On each completed transfer it emits one record (addr, data, dir, size, burst, resp) into a DEPTH-deep buffer.
//  It also flags protocol violations and counts dropped records.
//  Sits beside any AHB-lite slave in the DVE/RTL harness; no effect on the bus.
// PARAMETERS
//  AW     32  address width
//  DW     32  data width (32 or 64)
//  RW     1   hresp width
//  DEPTH  8   record buffer depth (power of 2, >=2)
//  CW     16  width of drop/transfer counters
// PORTS
//  hclk       in   1       bus clock; all logic on posedge
//  hreset     in   1       synchronous, active-high reset
//  hsel       in   1       slave select (tap)
//  haddr      in   AW      address (tap)
//  htrans     in   2       transfer type (tap)
//  hwrite     in   1       direction (tap)
//  hsize      in   3       size (tap)
//  hburst     in   3       burst type (tap)
//  hwdata     in   DW      write data (tap)
//  hrdata     in   DW      read data (tap)
//  hready     in   1       transfer done (tap)
//  hresp      in   RW      response (tap)
//  rec_valid  out  1       record available at buffer head
//  rec_ready  in   1       consumer pops head when rec_valid&rec_ready
//  rec_addr   out  AW      head record address
//  rec_data   out  DW      head record data (hwdata for write, hrdata for read)
//  rec_write  out  1       head record direction
//  rec_size   out  3       head record hsize
//  rec_burst  out  3       head record hburst
//  rec_resp   out  RW      head record response
//  txn_cnt    out  CW      completed transfers, saturating
//  drop_cnt   out  CW      records lost to a full buffer, saturating
//  overflow   out  1       sticky; set on first drop
//  err_align  out  1       1-cycle pulse: accepted addr misaligned to hsize
//  err_size   out  1       1-cycle pulse: hsize > log2(DW/8)
//  err_seq    out  1       1-cycle pulse: SEQ/BUSY with no burst in progress
// BEHAVIOUR
//  Reset: all outputs 0, buffer empty, pending phase cleared, counters 0. Reset mid-transfer discards the pending phase.
//  Address-phase accept: hsel & hready & htrans[1]. Latch addr/write/size/burst into the pending register and set pend=1.
//  Data-phase complete: pend & hready. Capture data (hwdata if write, else hrdata) and hresp. Push the record.
//    A new accept in the same cycle reloads pend (back-to-back pipelining, no gap).
//  Error response: hresp!=0 with hready=0, then hready=1. Record the resp captured on the hready=1 cycle.
//    Wait states (hready=0, hresp=0) hold pend and do not push.
//  IDLE (htrans=00) never creates a record. BUSY holds burst state and does not create a record.
//  Burst tracking: in_burst is set on accepted NONSEQ with hburst!=0 and cleared on accepted NONSEQ/IDLE with hsel.
//    err_seq pulses when hsel & hready & htrans in {SEQ,BUSY} & !in_burst.
//  err_align and err_size are evaluated only on address-phase accept and pulse the following cycle.
//    Misaligned means haddr & ((1<<hsize)-1) != 0.
//  Record latency: rec_valid rises the cycle after data-phase completion. The buffer is first-word-fall-through; rec_* are registered.
//  Push/pop arbitration:
//    Full and pop in the same cycle: push accepted, count unchanged.
//    Full and no pop: record dropped, drop_cnt+1, overflow=1.
//    Empty: rec_valid=0, and rec_* hold their last value.
//  txn_cnt increments on every data-phase completion, including dropped records and error responses.
//  Counters saturate at 2^CW-1 with no wrap. Buffer pointers wrap modulo DEPTH.
// TESTING
//  1. Single write: NONSEQ haddr=0x10, hwrite=1, hsize=2, then hwdata=0xDEADBEEF with hready=1
//     -> rec_valid next cycle; rec_addr=0x10, rec_data=0xDEADBEEF, rec_write=1, rec_resp=0, txn_cnt=1.
//  2. Read with 2 wait states at 0x20, hrdata=0xA5A5A5A5 on the third cycle
//     -> exactly one record with rec_data=0xA5A5A5A5; no record during the wait states.
//  3. Two-cycle ERROR response on a write to 0x40
//     -> record has rec_resp=1; the next NONSEQ is accepted normally.
//  4. INCR4 burst of 4 back-to-back writes with rec_ready=0 and DEPTH=4, then a 5th transfer
//     -> 4 records in order; drop_cnt=1, overflow=1, txn_cnt=5. With rec_ready=1 all 4 drain in 4 cycles.
//  5. Protocol checks:
//     SEQ with no prior NONSEQ -> err_seq pulse.
//     haddr=0x3, hsize=2 -> err_align pulse.
//     hsize=3 with DW=32 -> err_size pulse.
//  6. hreset asserted mid data-phase with 3 records buffered
//     -> next cycle rec_valid=0, counters 0, and no record emitted for the aborted transfer.

Source files
------------

// File: rtl/ahbl_txn_monitor_if.sv
// AHB-lite slave-port tap bundle.
//   master : the side that drives the bus (bench / real master+slave pair)
//   slave  : the passive monitor, every signal is an input
interface ahbl_txn_monitor_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RW = 1
);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic [RW-1:0] hresp;

  modport master (output hsel, haddr, htrans, hwrite, hsize, hburst,
                         hwdata, hrdata, hready, hresp);
  modport slave  (input  hsel, haddr, htrans, hwrite, hsize, hburst,
                         hwdata, hrdata, hready, hresp);
endinterface

// File: rtl/ahbl_txn_monitor.sv
// Passive AHB-lite transfer monitor.
// Tracks the address/data-phase pipeline of one slave port and pushes one
// record per completed transfer into a DEPTH-deep first-word-fall-through
// buffer with a registered head. Also counts transfers and dropped records
// and pulses protocol-violation flags.
// Ports:
//   hclk, hreset        clock, synchronous active-high reset
//   tap                 AHB-lite tap (slave modport, inputs only)
//   rec_valid/ready     head-of-buffer handshake; pop on valid & ready
//   rec_addr..rec_resp  head record fields (hold when empty)
//   txn_cnt, drop_cnt   saturating transfer / dropped-record counters
//   overflow            sticky, set on first drop
//   err_align/size/seq  one-cycle protocol error pulses
module ahbl_txn_monitor #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int RW    = 1,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic          hclk,
  input  logic          hreset,
  ahbl_txn_monitor_if.slave tap,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [AW-1:0] rec_addr,
  output logic [DW-1:0] rec_data,
  output logic          rec_write,
  output logic [2:0]    rec_size,
  output logic [2:0]    rec_burst,
  output logic [RW-1:0] rec_resp,
  output logic [CW-1:0] txn_cnt,
  output logic [CW-1:0] drop_cnt,
  output logic          overflow,
  output logic          err_align,
  output logic          err_size,
  output logic          err_seq
);
  localparam int PW       = $clog2(DEPTH);
  localparam int MAX_SIZE = $clog2(DW / 8);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
  } req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [RW-1:0] resp;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          head, head_n, rec_in;
  req_t          pnd;
  logic          pend, in_burst;
  logic [PW-1:0] wptr, rptr, rptr_n;
  logic [PW:0]   cnt, cnt_n;
  logic          accept, done, full, pop, push, drop;
  logic          misalign, oversize, seq_bad;

  assign accept = tap.hsel & tap.hready & tap.htrans[1];
  assign done   = pend & tap.hready;
  assign full   = (cnt == (PW+1)'(DEPTH));
  assign pop    = rec_valid & rec_ready;
  // a full buffer still takes the push when the head leaves the same cycle
  assign push   = done & (~full | pop);
  assign drop   = done & full & ~pop;

  assign misalign = (tap.haddr & ((AW'(1) << tap.hsize) - AW'(1))) != '0;
  assign oversize = tap.hsize > 3'(MAX_SIZE);
  // htrans[0] set covers both BUSY (01) and SEQ (11)
  assign seq_bad  = tap.hsel & tap.hready & tap.htrans[0] & ~in_burst;

  always_comb begin
    rec_in       = '0;
    rec_in.addr  = pnd.addr;
    rec_in.data  = pnd.write ? tap.hwdata : tap.hrdata;
    rec_in.write = pnd.write;
    rec_in.size  = pnd.size;
    rec_in.burst = pnd.burst;
    rec_in.resp  = tap.hresp;
    rptr_n = rptr + PW'(pop);
    cnt_n  = cnt + (PW+1)'(push) - (PW+1)'(pop);
    // if the buffer is empty once the pop is applied, the new head is the
    // record arriving this cycle (it is not yet visible in mem)
    head_n = (cnt == (PW+1)'(pop)) ? rec_in : mem[rptr_n];
  end

  // storage needs no reset: cnt/ptrs decide what is valid
  always_ff @(posedge hclk) begin
    if (push) mem[wptr] <= rec_in;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      pend      <= 1'b0;
      pnd       <= '0;
      in_burst  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      head      <= '0;
      rec_valid <= 1'b0;
      txn_cnt   <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      err_align <= 1'b0;
      err_size  <= 1'b0;
      err_seq   <= 1'b0;
    end else begin
      // a fresh accept reloads the pending phase even while one completes
      if (accept) begin
        pend      <= 1'b1;
        pnd.addr  <= tap.haddr;
        pnd.write <= tap.hwrite;
        pnd.size  <= tap.hsize;
        pnd.burst <= tap.hburst;
      end else if (done) begin
        pend <= 1'b0;
      end

      if (tap.hsel & tap.hready) begin
        if (tap.htrans == 2'b10)      in_burst <= (tap.hburst != 3'd0);
        else if (tap.htrans == 2'b00) in_burst <= 1'b0;
      end

      if (push) wptr <= wptr + PW'(1);
      rptr      <= rptr_n;
      cnt       <= cnt_n;
      rec_valid <= (cnt_n != '0);
      if (cnt_n != '0) head <= head_n;

      if (done && txn_cnt != '1)  txn_cnt  <= txn_cnt + CW'(1);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CW'(1);
      if (drop) overflow <= 1'b1;

      err_align <= accept & misalign;
      err_size  <= accept & oversize;
      err_seq   <= seq_bad;
    end
  end

  assign rec_addr  = head.addr;
  assign rec_data  = head.data;
  assign rec_write = head.write;
  assign rec_size  = head.size;
  assign rec_burst = head.burst;
  assign rec_resp  = head.resp;

endmodule

// File: tb/tb_ahbl_txn_monitor.sv
// Bench for ahbl_txn_monitor: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based transfer model.
module tb_ahbl_txn_monitor;
  localparam int AW = 32, DW = 32, RW = 1, DEPTH = 4, CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [RW-1:0] resp;
  } rec_t;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  ahbl_txn_monitor_if #(.AW(AW), .DW(DW), .RW(RW)) bus ();

  logic          rec_valid, rec_ready;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_data;
  logic          rec_write;
  logic [2:0]    rec_size, rec_burst;
  logic [RW-1:0] rec_resp;
  logic [CW-1:0] txn_cnt, drop_cnt;
  logic          overflow, err_align, err_size, err_seq;

  ahbl_txn_monitor #(.AW(AW), .DW(DW), .RW(RW), .DEPTH(DEPTH), .CW(CW)) dut (
    .hclk(hclk), .hreset(hreset), .tap(bus.slave),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_addr(rec_addr), .rec_data(rec_data), .rec_write(rec_write),
    .rec_size(rec_size), .rec_burst(rec_burst), .rec_resp(rec_resp),
    .txn_cnt(txn_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
    .err_align(err_align), .err_size(err_size), .err_seq(err_seq)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  rec_t q[$];
  rec_t m_last;
  logic          m_pend, m_inburst, m_ovf;
  logic [AW-1:0] m_paddr;
  logic          m_pwrite;
  logic [2:0]    m_psize, m_pburst;
  int            m_txn, m_drop;
  logic          e_align, e_size, e_seq;

  task automatic model_reset();
    q.delete();
    m_last = '0; m_pend = 0; m_inburst = 0; m_ovf = 0;
    m_paddr = '0; m_pwrite = 0; m_psize = '0; m_pburst = '0;
    m_txn = 0; m_drop = 0; e_align = 0; e_size = 0; e_seq = 0;
  endtask

  task automatic model_step();
    bit acc, cmp, pop;
    rec_t r;
    if (hreset) begin
      model_reset();
      return;
    end
    acc = bus.hsel && bus.hready && bus.htrans[1];
    cmp = m_pend && bus.hready;
    pop = (q.size() != 0) && rec_ready;
    e_align = acc && ((bus.haddr % (32'd1 << bus.hsize)) != 0);
    e_size  = acc && ((1 << bus.hsize) > DW / 8);
    e_seq   = bus.hsel && bus.hready && (bus.htrans == 2'd1 || bus.htrans == 2'd3) && !m_inburst;
    if (pop) void'(q.pop_front());
    if (cmp) begin
      if (m_txn < MAXC) m_txn++;
      r.addr = m_paddr; r.write = m_pwrite; r.size = m_psize; r.burst = m_pburst;
      r.data = m_pwrite ? bus.hwdata : bus.hrdata;
      r.resp = bus.hresp;
      if (q.size() < DEPTH) q.push_back(r);
      else begin
        if (m_drop < MAXC) m_drop++;
        m_ovf = 1;
      end
    end
    if (acc) begin
      m_pend = 1; m_paddr = bus.haddr; m_pwrite = bus.hwrite;
      m_psize = bus.hsize; m_pburst = bus.hburst;
    end else if (cmp) m_pend = 0;
    if (bus.hsel && bus.hready) begin
      if (bus.htrans == 2'd2) m_inburst = (bus.hburst != 0);
      else if (bus.htrans == 2'd0) m_inburst = 0;
    end
    if (q.size() != 0) m_last = q[0];
  endtask

  task automatic compare();
    chk("rec_valid", rec_valid, q.size() != 0);
    chk("rec_addr",  rec_addr,  m_last.addr);
    chk("rec_data",  rec_data,  m_last.data);
    chk("rec_write", rec_write, m_last.write);
    chk("rec_size",  rec_size,  m_last.size);
    chk("rec_burst", rec_burst, m_last.burst);
    chk("rec_resp",  rec_resp,  m_last.resp);
    chk("txn_cnt",   txn_cnt,   m_txn);
    chk("drop_cnt",  drop_cnt,  m_drop);
    chk("overflow",  overflow,  m_ovf);
    chk("err_align", err_align, e_align);
    chk("err_size",  err_size,  e_size);
    chk("err_seq",   err_seq,   e_seq);
  endtask

  // inputs change 1 time unit after posedge, outputs sampled there too
  task automatic tick();
    @(posedge hclk);
    model_step();
    #1;
    compare();
  endtask

  task automatic addr_ph(input logic [1:0] tr, input logic [AW-1:0] a, input logic wr,
                         input logic [2:0] sz, input logic [2:0] bu);
    bus.hsel = 1; bus.htrans = tr; bus.haddr = a; bus.hwrite = wr;
    bus.hsize = sz; bus.hburst = bu; bus.hready = 1; bus.hresp = '0;
  endtask

  task automatic idle();
    bus.hsel = 1; bus.htrans = 2'd0; bus.hready = 1; bus.hresp = '0;
  endtask

  task automatic do_reset();
    hreset = 1; idle(); tick(); hreset = 0;
  endtask

  initial begin
    bus.hsel = 0; bus.haddr = '0; bus.htrans = '0; bus.hwrite = 0; bus.hsize = '0;
    bus.hburst = '0; bus.hwdata = '0; bus.hrdata = '0; bus.hready = 1; bus.hresp = '0;
    rec_ready = 0;
    model_reset();
    hreset = 1; tick(); tick();
    chk("rst_valid", rec_valid, 0);
    chk("rst_txn", txn_cnt, 0);
    hreset = 0;

    // single write
    addr_ph(2'd2, 'h10, 1, 3'd2, 3'd0); tick();
    idle(); bus.hwdata = 'hDEADBEEF; tick();
    chk("t1_valid", rec_valid, 1);
    chk("t1_addr", rec_addr, 'h10);
    chk("t1_data", rec_data, 'hDEADBEEF);
    chk("t1_write", rec_write, 1);
    chk("t1_resp", rec_resp, 0);
    chk("t1_txn", txn_cnt, 1);
    rec_ready = 1; tick(); rec_ready = 0;
    chk("t1_empty", rec_valid, 0);
    chk("t1_hold", rec_addr, 'h10);

    // read with two wait states
    addr_ph(2'd2, 'h20, 0, 3'd2, 3'd0); tick();
    idle(); bus.hready = 0; bus.hrdata = 'h11111111; tick();
    chk("t2_wait1", rec_valid, 0);
    tick();
    chk("t2_wait2", rec_valid, 0);
    bus.hready = 1; bus.hrdata = 'hA5A5A5A5; tick();
    chk("t2_valid", rec_valid, 1);
    chk("t2_data", rec_data, 'hA5A5A5A5);
    chk("t2_txn", txn_cnt, 2);
    rec_ready = 1; tick(); rec_ready = 0;
    chk("t2_once", rec_valid, 0);

    // two-cycle ERROR response, then a normal transfer
    addr_ph(2'd2, 'h40, 1, 3'd2, 3'd0); tick();
    idle(); bus.hready = 0; bus.hresp = 1; tick();
    bus.hready = 1; tick();
    chk("t3_resp", rec_resp, 1);
    addr_ph(2'd2, 'h44, 1, 3'd2, 3'd0); tick();
    idle(); bus.hwdata = 'h12345678; tick();
    rec_ready = 1; tick(); rec_ready = 0;
    chk("t3_next_addr", rec_addr, 'h44);
    chk("t3_next_resp", rec_resp, 0);
    rec_ready = 1; tick(); rec_ready = 0;

    // INCR4 into a 4-deep buffer plus one extra transfer
    do_reset();
    addr_ph(2'd2, 'h100, 1, 3'd2, 3'd3); tick();
    for (int i = 1; i < 4; i++) begin
      addr_ph(2'd3, 'h100 + 4 * i, 1, 3'd2, 3'd3); bus.hwdata = 'hB000 + i - 1; tick();
    end
    addr_ph(2'd2, 'h200, 1, 3'd2, 3'd0); bus.hwdata = 'hB003; tick();
    idle(); bus.hwdata = 'hB004; tick();
    chk("t4_txn", txn_cnt, 5);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_ovf", overflow, 1);
    rec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", rec_addr, 'h100 + 4 * i);
      tick();
    end
    rec_ready = 0;
    chk("t4_drained", rec_valid, 0);

    // protocol checks
    bus.hsel = 1; bus.htrans = 2'd3; bus.haddr = 'h300; bus.hburst = 3'd0; bus.hready = 1; tick();
    chk("t5_seq", err_seq, 1);
    idle(); tick();
    chk("t5_seq_pulse", err_seq, 0);
    addr_ph(2'd2, 'h3, 0, 3'd2, 3'd0); tick();
    chk("t5_align", err_align, 1);
    idle(); tick();
    chk("t5_align_pulse", err_align, 0);
    addr_ph(2'd2, 'h0, 0, 3'd3, 3'd0); tick();
    chk("t5_size", err_size, 1);
    idle(); tick();

    // reset in the middle of a data phase with three records held
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addr_ph(2'd2, 'h500 + 4 * i, 1, 3'd2, 3'd0); bus.hwdata = 'hC000 + i; tick();
    end
    addr_ph(2'd2, 'h50C, 1, 3'd2, 3'd0); bus.hwdata = 'hC002; tick();
    idle(); bus.hready = 0; tick();
    chk("t6_held", rec_valid, 1);
    hreset = 1; bus.hready = 1; tick(); hreset = 0;
    chk("t6_valid", rec_valid, 0);
    chk("t6_txn", txn_cnt, 0);
    idle(); tick(); tick();
    chk("t6_no_rec", rec_valid, 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.hsel   = ($urandom_range(7) != 0);
      bus.htrans = 2'($urandom_range(3));
      bus.hsize  = 3'($urandom_range(3));
      bus.haddr  = $urandom;
      if ($urandom_range(3) != 0) bus.haddr = bus.haddr & ~((32'd1 << bus.hsize) - 1);
      bus.hwrite = 1'($urandom_range(1));
      bus.hburst = 3'($urandom_range(7));
      bus.hready = ($urandom_range(3) != 0);
      bus.hresp  = RW'($urandom_range(3) == 0);
      bus.hwdata = $urandom;
      bus.hrdata = $urandom;
      rec_ready  = ((c / 64) % 2 == 0) ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
      hreset     = ($urandom_range(199) == 0);
      tick();
    end
    hreset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
